pwm_sequencer: RTL

Scheduler that drives the photonic-switch PWM generator's configuration inputs (A_val, B_val, load) from a small programmable pattern table. The block steps through up to DEPTH (A,B) value pairs, one per frame, and issues a single-cycle load at each frame boundary. It sits between the host/config interface and the PWM generator, in the core-clock domain.

---
 rtl/pwm_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: steps through a small (A,B) pattern table, presenting one
// entry per frame to the PWM generator together with a one-cycle load pulse.
module pwm_sequencer #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int FW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_a,
  input  logic [WIDTH-1:0] wr_b,
  output logic             wr_ready,
  input  logic [AW:0]      seq_len,
  input  logic [FW-1:0]    frame_period,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] A_val,
  output logic [WIDTH-1:0] B_val,
  output logic             load,
  output logic [AW-1:0]    idx,
  output logic             wrap,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [AW:0]      len_q, len_d;
  logic [FW-1:0]    per_q, per_d;
  logic [FW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    nxt_q, nxt_d;
  logic             first_q, first_d;
  logic             stop_pending_q, stop_pending_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             load_q, load_d;
  logic             wrap_q, wrap_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             wr_ready_q, wr_ready_d;
  logic [WIDTH-1:0] tab_a_q [DEPTH];
  logic [WIDTH-1:0] tab_a_d [DEPTH];
  logic [WIDTH-1:0] tab_b_q [DEPTH];
  logic [WIDTH-1:0] tab_b_d [DEPTH];

  assign A_val    = a_q;
  assign B_val    = b_q;
  assign load     = load_q;
  assign wrap     = wrap_q;
  assign idx      = idx_q;
  assign busy     = busy_q;
  assign wr_ready = wr_ready_q;

  // Next-state logic: frame counting, table stepping, stop handling and table writes
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    per_d          = per_q;
    cnt_d          = cnt_q;
    nxt_d          = nxt_q;
    first_d        = first_q;
    stop_pending_d = stop_pending_q;
    a_d            = a_q;
    b_d            = b_q;
    idx_d          = idx_q;
    load_d         = 1'b0;
    wrap_d         = 1'b0;
    tab_a_d        = tab_a_q;
    tab_b_d        = tab_b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_RUN;
          if (seq_len == '0)
            len_d = (AW+1)'(1);
          else if (seq_len > (AW+1)'(DEPTH))
            len_d = (AW+1)'(DEPTH);
          else
            len_d = seq_len;
          per_d          = (frame_period < FW'(2)) ? FW'(2) : frame_period;
          cnt_d          = '0;
          nxt_d          = '0;
          first_d        = 1'b1;
          stop_pending_d = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          if (stop_pending_q) begin
            state_d        = S_DRAIN;
            stop_pending_d = 1'b0;
          end else begin
            load_d  = 1'b1;
            a_d     = tab_a_q[nxt_q];
            b_d     = tab_b_q[nxt_q];
            idx_d   = nxt_q;
            wrap_d  = (nxt_q == '0) && !first_q;
            first_d = 1'b0;
            nxt_d   = ({1'b0, nxt_q} == (len_q - 1'b1)) ? '0 : nxt_q + 1'b1;
            cnt_d   = per_q - 1'b1;
            if (stop)
              stop_pending_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (stop)
            stop_pending_d = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    // Writes are held off for the cycle just before the table is read
    wr_ready_d = !((state_d == S_RUN) && (cnt_d == FW'(1)));

    if (wr_en && wr_ready_q) begin
      tab_a_d[wr_addr] = wr_a;
      tab_b_d[wr_addr] = wr_b;
    end
  end

  // State and output registers with asynchronous clear, including the table
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_q          <= (AW+1)'(1);
      per_q          <= FW'(2);
      cnt_q          <= '0;
      nxt_q          <= '0;
      first_q        <= 1'b1;
      stop_pending_q <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      load_q         <= 1'b0;
      wrap_q         <= 1'b0;
      idx_q          <= '0;
      busy_q         <= 1'b0;
      wr_ready_q     <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        tab_a_q[i] <= '0;
        tab_b_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      per_q          <= per_d;
      cnt_q          <= cnt_d;
      nxt_q          <= nxt_d;
      first_q        <= first_d;
      stop_pending_q <= stop_pending_d;
      a_q            <= a_d;
      b_q            <= b_d;
      load_q         <= load_d;
      wrap_q         <= wrap_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      wr_ready_q     <= wr_ready_d;
      tab_a_q        <= tab_a_d;
      tab_b_q        <= tab_b_d;
    end
  end

endmodule
